// File: rtl/hough_sequencer.sv
// Hough accumulator sequencer: optional accumulator clear, vote pass-through, drain, then peak search.
// Define HOUGH_SEQ_CLEAR_EN to clear the accumulator RAM in-block; otherwise it is cleared externally.
module hough_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Width,
  input  logic [7:0]  Height,
  input  logic        FrameIn,
  input  logic        VoteValid,
  input  logic [15:0] VoteAddr,
  output logic        VoteReady,
  output logic [15:0] AccAddr,
  output logic        AccWe,
  output logic        AccInc,
  output logic        AccRd,
  input  logic [10:0] AccRdData,
  output logic [15:0] PeakAddr,
  output logic [10:0] PeakValue,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  DropCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef HOUGH_SEQ_CLEAR_EN
    S_CLEAR,
`endif
    S_WAIT,
    S_ACCUM,
    S_DRAIN,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] max_addr_q, max_addr_d;
  logic [10:0] max_val_q, max_val_d;
  logic [15:0] peak_addr_q, peak_addr_d;
  logic [10:0] peak_val_q, peak_val_d;
  logic [7:0]  drop_q, drop_d;

  logic [15:0] prod;
  logic        acc_win;
  logic        cmp_gt;
  logic [15:0] cmp_addr;

  assign prod     = 16'(Width) * 16'(Height);
  assign acc_win  = (state_q == S_ACCUM) || (state_q == S_DRAIN);
  // Read data lags AccRd by one cycle, so the compared address is cnt_q-1.
  assign cmp_addr = cnt_q - 16'd1;
  assign cmp_gt   = (state_q == S_SEARCH) && (cnt_q != 16'd0) && (AccRdData > max_val_q);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    max_addr_d  = max_addr_q;
    max_val_d   = max_val_q;
    peak_addr_d = peak_addr_q;
    peak_val_d  = peak_val_q;
    drop_d      = drop_q;
    VoteReady   = acc_win;
    AccAddr     = 16'd0;
    AccWe       = 1'b0;
    AccInc      = 1'b0;
    AccRd       = 1'b0;

    if (VoteValid && !acc_win && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          n_d        = prod;
          cnt_d      = 16'd0;
          max_addr_d = 16'd0;
          max_val_d  = 11'd0;
          drop_d     = 8'd0;
          if (prod == 16'd0) begin
            state_d     = S_DONE;
            peak_addr_d = 16'd0;
            peak_val_d  = 11'd0;
          end else begin
`ifdef HOUGH_SEQ_CLEAR_EN
            state_d = S_CLEAR;
`else
            state_d = S_WAIT;
`endif
          end
        end
      end
`ifdef HOUGH_SEQ_CLEAR_EN
      S_CLEAR: begin
        AccWe   = 1'b1;
        AccAddr = cnt_q;
        if (cnt_q == n_q - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      S_WAIT: begin
        if (FrameIn) state_d = S_ACCUM;
      end
      S_ACCUM, S_DRAIN: begin
        if (VoteValid) begin
          AccWe   = 1'b1;
          AccInc  = 1'b1;
          AccAddr = VoteAddr;
        end
        if (state_q == S_ACCUM) begin
          if (!FrameIn) begin
            state_d = S_DRAIN;
            cnt_d   = 16'd0;
          end
        end else if (cnt_q == 16'd7) begin
          state_d = S_SEARCH;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SEARCH: begin
        if (cnt_q < n_q) begin
          AccRd   = 1'b1;
          AccAddr = cnt_q;
        end
        // Strictly greater only: ties keep the lowest address.
        if (cmp_gt) begin
          max_val_d  = AccRdData;
          max_addr_d = cmp_addr;
        end
        if (cnt_q == n_q) begin
          state_d     = S_DONE;
          peak_addr_d = max_addr_d;
          peak_val_d  = max_val_d;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      n_q         <= 16'd0;
      cnt_q       <= 16'd0;
      max_addr_q  <= 16'd0;
      max_val_q   <= 11'd0;
      peak_addr_q <= 16'd0;
      peak_val_q  <= 11'd0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      max_addr_q  <= max_addr_d;
      max_val_q   <= max_val_d;
      peak_addr_q <= peak_addr_d;
      peak_val_q  <= peak_val_d;
      drop_q      <= drop_d;
    end
  end

  assign PeakAddr  = peak_addr_q;
  assign PeakValue = peak_val_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign DropCnt   = drop_q;

endmodule

// File: tb/tb_hough_sequencer.sv
// Bench for hough_sequencer: expected RAM commands and results are queued by the stimulus and
// popped by a monitor; a small RAM model feeds AccRdData. Honors HOUGH_SEQ_CLEAR_EN like the DUT.
module tb_hough_sequencer;
  logic        Clk = 1'b0;
  logic        Reset, Start, FrameIn, VoteValid;
  logic [7:0]  Width, Height;
  logic [15:0] VoteAddr;
  logic        VoteReady, AccWe, AccInc, AccRd, Busy, Done;
  logic [15:0] AccAddr, PeakAddr;
  logic [10:0] AccRdData, PeakValue;
  logic [7:0]  DropCnt;

  always #5 Clk = ~Clk;

  hough_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Width(Width), .Height(Height),
    .FrameIn(FrameIn), .VoteValid(VoteValid), .VoteAddr(VoteAddr), .VoteReady(VoteReady),
    .AccAddr(AccAddr), .AccWe(AccWe), .AccInc(AccInc), .AccRd(AccRd), .AccRdData(AccRdData),
    .PeakAddr(PeakAddr), .PeakValue(PeakValue), .Busy(Busy), .Done(Done), .DropCnt(DropCnt)
  );

  typedef struct { int kind; int addr; int val; } ev_t;
  localparam int K_CLR = 0, K_INC = 1, K_RD = 2, K_DONE = 3, K_BAD = 4;

  ev_t sb[$];
  int  errors = 0, checks = 0;
  int  ref_acc[256];
  int  ref_drop = 0;
  int  exp_pa = 0, exp_pv = 0;
  bit  exp_rdy = 1'b0;

  // Accumulator RAM model (reads return one cycle later)
  logic [10:0] mem [256];
  logic [10:0] rdata = '0;
  bit          mem_fill = 1'b0, mem_garbage = 1'b0;
  assign AccRdData = rdata;

  always @(posedge Clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_garbage ? 11'(i * 7 + 3) : 11'd0;
    end else begin
      if (AccWe) mem[AccAddr[7:0]] <= AccInc ? mem[AccAddr[7:0]] + 11'd1 : 11'd0;
      if (AccRd) rdata <= mem[AccAddr[7:0]];
    end
  end

  // Monitor: every RAM command or Done pulse must match the next expected event.
  always @(negedge Clk) begin
    int  k, aa, av;
    ev_t e;
    if (VoteValid) begin
      checks++;
      if (VoteReady !== exp_rdy) begin
        errors++;
        $display("FAIL vote_ready: got %0b expected %0b", VoteReady, exp_rdy);
      end
    end
    if (Done || AccWe || AccRd) begin
      if (Done && (AccWe || AccRd))  k = K_BAD;
      else if (Done)                 k = K_DONE;
      else if (AccRd && AccWe)       k = K_BAD;
      else if (AccRd)                k = K_RD;
      else if (AccInc)               k = K_INC;
      else                           k = K_CLR;
      aa = (k == K_DONE) ? int'(PeakAddr) : int'(AccAddr);
      av = (k == K_DONE) ? int'(PeakValue) : 0;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got kind=%0d addr=%0d val=%0d, expected no command", k, aa, av);
      end else begin
        e = sb.pop_front();
        if (k != e.kind || aa != e.addr || av != e.val) begin
          errors++;
          $display("FAIL sb_event: got kind=%0d addr=%0d val=%0d expected kind=%0d addr=%0d val=%0d",
                   k, aa, av, e.kind, e.addr, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int a, input int v);
    ev_t e;
    e.kind = k; e.addr = a; e.val = v;
    sb.push_back(e);
  endtask

  // Vote on the current cycle; acc says whether the sequencer should take it.
  task automatic vote(input bit v, input int a, input bit acc);
    VoteValid = v;
    VoteAddr  = 16'(a);
    exp_rdy   = acc;
    if (v) begin
      if (acc) begin
        push(K_INC, a, 0);
        ref_acc[a]++;
      end else if (ref_drop < 255) begin
        ref_drop++;
      end
    end
  endtask

  // Peak: highest count, lowest address on ties, zero if nothing voted.
  task automatic calc_peak(input int n);
    exp_pa = 0; exp_pv = 0;
    for (int a = 0; a < n; a++)
      if (ref_acc[a] > exp_pv) begin exp_pv = ref_acc[a]; exp_pa = a; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, Busy, Done, AccWe, AccInc, AccRd, VoteReady}, 32'd0);
    chk({tag, "_accaddr"}, AccAddr, 0);
    chk({tag, "_peakaddr"}, PeakAddr, 0);
    chk({tag, "_peakval"}, PeakValue, 0);
    chk({tag, "_dropcnt"}, DropCnt, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int f, input bit directed,
                           input bit edge_tests, input int abort_at);
    int n, a;
    bit seen;
    n = w * h;
    for (int i = 0; i < 256; i++) ref_acc[i] = 0;
    tick();
    mem_fill = 1'b1;
`ifdef HOUGH_SEQ_CLEAR_EN
    mem_garbage = 1'b1;
    for (int i = 0; i < n; i++) push(K_CLR, i, 0);
`else
    mem_garbage = 1'b0;
`endif
    tick();
    mem_fill = 1'b0;
    Start = 1'b1; Width = 8'(w); Height = 8'(h);
    tick();
    Start = 1'b0;
    ref_drop = 0;
`ifdef HOUGH_SEQ_CLEAR_EN
    repeat (n) tick();
`endif
    at_neg();
    chk("wait_busy", Busy, 1);
    chk("drop_cleared", DropCnt, ref_drop);
    // Start with a zero frame while busy must be ignored
    Start = 1'b1; Width = 8'd0;
    tick();
    Start = 1'b0;
    at_neg();
    chk("start_ignored_busy", Busy, 1);
    FrameIn = 1'b1;
    tick();
    for (int i = 0; i < f; i++) begin
      FrameIn = (i < f - 1);
      if (directed) vote(i >= 2 && i <= 7, (i % 2 == 0) ? 5 : 9, 1'b1);
      else          vote(1'($urandom_range(0, 1)), int'($urandom_range(0, n - 1)), 1'b1);
      tick();
    end
    for (int d = 1; d <= 8; d++) begin
      if (edge_tests && d == 8) vote(1'b1, int'($urandom_range(0, n - 1)), 1'b1);
      else if (directed)        vote(1'b0, 0, 1'b1);
      else                      vote(1'($urandom_range(0, 1)), int'($urandom_range(0, n - 1)), 1'b1);
      tick();
    end
    // First search cycle: a vote here must be refused
    a = int'($urandom_range(0, n - 1));
    vote(edge_tests, a, 1'b0);
    for (int i = 0; i < n; i++) push(K_RD, i, 0);
    calc_peak(n);
    if (abort_at < 0) push(K_DONE, exp_pa, exp_pv);
    tick();
    VoteValid = 1'b0;
    if (edge_tests) begin
      at_neg();
      chk("drop_after_drain", DropCnt, ref_drop);
    end
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
      Reset = 1'b1;
      tick();
      sb.delete();
      at_neg();
      chk_all_zero("rst_mid_search");
      Reset = 1'b0;
      ref_drop = 0; exp_pa = 0; exp_pv = 0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick(); at_neg();
        if (Done) seen = 1'b1;
      end
      chk("no_done_after_reset", seen, 0);
      return;
    end
    seen = 1'b0;
    for (int k = 0; k < n + 20 && !seen; k++) begin
      at_neg();
      if (Done) seen = 1'b1;
      else tick();
    end
    chk("done_seen", seen, 1);
    tick(); tick();
    at_neg();
    chk("idle_busy", Busy, 0);
    chk("peak_addr_held", PeakAddr, exp_pa);
    chk("peak_val_held", PeakValue, exp_pv);
    chk("dropcnt_end", DropCnt, ref_drop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    Reset = 1'b1; Start = 1'b0; FrameIn = 1'b0; VoteValid = 1'b0;
    VoteAddr = '0; Width = '0; Height = '0;
    repeat (3) tick();
    at_neg();
    chk_all_zero("reset");
    Reset = 1'b0;

    run_frame(4, 3, 20, 1'b1, 1'b0, -1);
    chk("frame_peak_addr", PeakAddr, 5);
    chk("frame_peak_val", PeakValue, 3);

    for (int r = 0; r < 4; r++)
      run_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                int'($urandom_range(8, 30)), 1'b0, 1'b1, -1);

    for (int i = 0; i < 300; i++) begin
      vote(1'b1, int'($urandom_range(0, 255)), 1'b0);
      tick();
    end
    VoteValid = 1'b0;
    at_neg();
    chk("idle_drop_saturate", DropCnt, 255);

    Start = 1'b1; Width = 8'd0; Height = 8'd5;
    push(K_DONE, 0, 0);
    tick();
    Start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      at_neg();
      if (Done) seen = 1'b1;
      else tick();
    end
    chk("zero_frame_done", seen, 1);
    tick();
    at_neg();
    chk("zero_frame_drop_cleared", DropCnt, 0);
    chk("zero_frame_idle", Busy, 0);

    run_frame(5, 4, 12, 1'b0, 1'b0, 7);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
